// File: rtl/unidade_controle_if.sv
// Control bundle between the multicycle control FSM and the datapath:
// instruction/flag inputs to the FSM and every datapath strobe it drives.
interface unidade_controle_if;
    logic [31:0] inst;
    logic        Zero;
    logic        DpReset;
    logic        PCWrite;
    logic        PCSrc;
    logic [2:0]  ALUFunct;
    logic        ALUSrcA;
    logic [2:0]  ALUSrcB;
    logic        LoadRegA;
    logic        LoadRegB;
    logic        LoadALUOut;
    logic        LoadIR;
    logic        LoadMDR;
    logic        IMemLoad;
    logic        DMemLoad;
    logic        RegWrite;
    logic        MemToReg;
    logic        Halted;
    logic [3:0]  State;

    modport master (
        input  inst, Zero,
        output DpReset, PCWrite, PCSrc, ALUFunct, ALUSrcA, ALUSrcB,
               LoadRegA, LoadRegB, LoadALUOut, LoadIR, LoadMDR,
               IMemLoad, DMemLoad, RegWrite, MemToReg, Halted, State
    );

    modport slave (
        output inst, Zero,
        input  DpReset, PCWrite, PCSrc, ALUFunct, ALUSrcA, ALUSrcB,
               LoadRegA, LoadRegB, LoadALUOut, LoadIR, LoadMDR,
               IMemLoad, DMemLoad, RegWrite, MemToReg, Halted, State
    );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle RV64I-subset control FSM: sequences PC/IR/A/B/ALUOut/MDR and
// memories, with MEM_WAIT extra cycles per memory access.
module unidade_controle #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic               clk,
    input  logic               Reset,
    unidade_controle_if.master ctrl
);

    localparam int unsigned CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_EXEC_LUI = 4'd5,
        S_ADDR     = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_NEXT_PC  = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] wcnt, wcnt_next;
    logic          mem_last;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = ctrl.inst[6:0];
    assign funct3      = ctrl.inst[14:12];
    assign funct7      = ctrl.inst[31:25];
    assign unused_bits = ^{ctrl.inst[24:15], ctrl.inst[11:7]};
    assign mem_last    = (wcnt == CW'(MEM_WAIT));

    // Supported encodings recognised in DECODE
    logic is_add, is_sub, is_and, is_r, is_addi, is_lui, is_mem, is_beq, is_bne;
    assign is_add  = (opcode == OP_R) && (funct3 == 3'b000) && (funct7 == 7'h00);
    assign is_sub  = (opcode == OP_R) && (funct3 == 3'b000) && (funct7 == 7'h20);
    assign is_and  = (opcode == OP_R) && (funct3 == 3'b111) && (funct7 == 7'h00);
    assign is_r    = is_add || is_sub || is_and;
    assign is_addi = (opcode == OP_I) && (funct3 == 3'b000);
    assign is_lui  = (opcode == OP_LUI);
    assign is_mem  = ((opcode == OP_LD) || (opcode == OP_SD)) && (funct3 == 3'b011);
    assign is_beq  = (opcode == OP_BR) && (funct3 == 3'b000);
    assign is_bne  = (opcode == OP_BR) && (funct3 == 3'b001);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_RESET;
            wcnt  <= '0;
        end else begin
            state <= next_state;
            wcnt  <= wcnt_next;
        end
    end

    always_comb begin
        next_state      = state;
        wcnt_next       = '0;
        ctrl.DpReset    = 1'b0;
        ctrl.PCWrite    = 1'b0;
        ctrl.PCSrc      = 1'b0;
        ctrl.ALUFunct   = 3'b000;
        ctrl.ALUSrcA    = 1'b0;
        ctrl.ALUSrcB    = 3'b000;
        ctrl.LoadRegA   = 1'b0;
        ctrl.LoadRegB   = 1'b0;
        ctrl.LoadALUOut = 1'b0;
        ctrl.LoadIR     = 1'b0;
        ctrl.LoadMDR    = 1'b0;
        ctrl.IMemLoad   = 1'b0;
        ctrl.DMemLoad   = 1'b0;
        ctrl.RegWrite   = 1'b0;
        ctrl.MemToReg   = 1'b0;
        ctrl.Halted     = 1'b0;
        ctrl.State      = state;

        case (state)
            S_RESET: begin
                ctrl.DpReset = 1'b1;
                next_state   = S_FETCH;
            end
            S_FETCH: begin
                if (mem_last) begin
                    ctrl.LoadIR = 1'b1;
                    next_state  = S_DECODE;
                end else begin
                    wcnt_next = wcnt + CW'(1);
                end
            end
            S_DECODE: begin
                // Branch target PC + (imm<<1) parked in ALUOut
                ctrl.LoadRegA   = 1'b1;
                ctrl.LoadRegB   = 1'b1;
                ctrl.ALUSrcB    = 3'b011;
                ctrl.ALUFunct   = 3'b001;
                ctrl.LoadALUOut = 1'b1;
                if (is_r)                  next_state = S_EXEC_R;
                else if (is_addi)          next_state = S_EXEC_I;
                else if (is_lui)           next_state = S_EXEC_LUI;
                else if (is_mem)           next_state = S_ADDR;
                else if (is_beq || is_bne) next_state = S_BRANCH;
                else                       next_state = S_TRAP;
            end
            S_EXEC_R: begin
                ctrl.ALUSrcA    = 1'b1;
                ctrl.LoadALUOut = 1'b1;
                if (funct3 == 3'b111)  ctrl.ALUFunct = 3'b011;
                else if (funct7[5])    ctrl.ALUFunct = 3'b010;
                else                   ctrl.ALUFunct = 3'b001;
                next_state = S_WB_ALU;
            end
            S_EXEC_I: begin
                ctrl.ALUSrcA    = 1'b1;
                ctrl.ALUSrcB    = 3'b010;
                ctrl.ALUFunct   = 3'b001;
                ctrl.LoadALUOut = 1'b1;
                next_state      = S_WB_ALU;
            end
            S_EXEC_LUI: begin
                ctrl.ALUSrcB    = 3'b010;
                ctrl.LoadALUOut = 1'b1;
                next_state      = S_WB_ALU;
            end
            S_ADDR: begin
                ctrl.ALUSrcA    = 1'b1;
                ctrl.ALUSrcB    = 3'b010;
                ctrl.ALUFunct   = 3'b001;
                ctrl.LoadALUOut = 1'b1;
                next_state      = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_last) begin
                    ctrl.LoadMDR = 1'b1;
                    next_state   = S_WB_MEM;
                end else begin
                    wcnt_next = wcnt + CW'(1);
                end
            end
            S_MEM_WR: begin
                ctrl.DMemLoad = 1'b1;
                if (mem_last) next_state = S_NEXT_PC;
                else          wcnt_next  = wcnt + CW'(1);
            end
            S_WB_ALU: begin
                ctrl.RegWrite = 1'b1;
                next_state    = S_NEXT_PC;
            end
            S_WB_MEM: begin
                ctrl.RegWrite = 1'b1;
                ctrl.MemToReg = 1'b1;
                next_state    = S_NEXT_PC;
            end
            S_BRANCH: begin
                ctrl.ALUSrcA  = 1'b1;
                ctrl.ALUFunct = 3'b010;
                if ((is_beq && ctrl.Zero) || (is_bne && !ctrl.Zero)) begin
                    ctrl.PCWrite = 1'b1;
                    ctrl.PCSrc   = 1'b1;
                    next_state   = S_FETCH;
                end else begin
                    next_state = S_NEXT_PC;
                end
            end
            S_NEXT_PC: begin
                ctrl.ALUSrcB  = 3'b001;
                ctrl.ALUFunct = 3'b001;
                ctrl.PCWrite  = 1'b1;
                next_state    = S_FETCH;
            end
            S_TRAP: begin
                ctrl.Halted = 1'b1;
                next_state  = S_TRAP;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: three instances (MEM_WAIT 0/1/2),
// directed instructions, per-cycle expected strobe vectors checked by a monitor.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] inst = '0;
    logic        zero = 1'b0;
    int          sel = 1;
    string       tname = "init";

    logic [23:0] obs [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        unidade_controle_if bus ();
        unidade_controle #(.MEM_WAIT(g)) dut (.clk(clk), .Reset(Reset), .ctrl(bus.master));
        assign bus.inst = inst;
        assign bus.Zero = zero;
        assign obs[g] = {bus.DpReset, bus.PCWrite, bus.PCSrc, bus.ALUFunct, bus.ALUSrcA,
                         bus.ALUSrcB, bus.LoadRegA, bus.LoadRegB, bus.LoadALUOut, bus.LoadIR,
                         bus.LoadMDR, bus.IMemLoad, bus.DMemLoad, bus.RegWrite, bus.MemToReg,
                         bus.Halted, bus.State};
    end

    // {DpReset,PCWrite,PCSrc}, ALUFunct, ALUSrcA, ALUSrcB,
    // {LdA,LdB,LdALUOut,LdIR,LdMDR}, {IMem,DMem,RegWrite,MemToReg,Halted}, State
    localparam logic [23:0] E_RESET   = {3'b100, 3'b000, 1'b0, 3'b000, 5'b00000, 5'b00000, 4'd0};
    localparam logic [23:0] E_FETCH_W = {3'b000, 3'b000, 1'b0, 3'b000, 5'b00000, 5'b00000, 4'd1};
    localparam logic [23:0] E_FETCH_L = {3'b000, 3'b000, 1'b0, 3'b000, 5'b00010, 5'b00000, 4'd1};
    localparam logic [23:0] E_DECODE  = {3'b000, 3'b001, 1'b0, 3'b011, 5'b11100, 5'b00000, 4'd2};
    localparam logic [23:0] E_EXR_ADD = {3'b000, 3'b001, 1'b1, 3'b000, 5'b00100, 5'b00000, 4'd3};
    localparam logic [23:0] E_EXR_SUB = {3'b000, 3'b010, 1'b1, 3'b000, 5'b00100, 5'b00000, 4'd3};
    localparam logic [23:0] E_EXR_AND = {3'b000, 3'b011, 1'b1, 3'b000, 5'b00100, 5'b00000, 4'd3};
    localparam logic [23:0] E_EXI     = {3'b000, 3'b001, 1'b1, 3'b010, 5'b00100, 5'b00000, 4'd4};
    localparam logic [23:0] E_LUI     = {3'b000, 3'b000, 1'b0, 3'b010, 5'b00100, 5'b00000, 4'd5};
    localparam logic [23:0] E_ADDR    = {3'b000, 3'b001, 1'b1, 3'b010, 5'b00100, 5'b00000, 4'd6};
    localparam logic [23:0] E_MRD_W   = {3'b000, 3'b000, 1'b0, 3'b000, 5'b00000, 5'b00000, 4'd7};
    localparam logic [23:0] E_MRD_L   = {3'b000, 3'b000, 1'b0, 3'b000, 5'b00001, 5'b00000, 4'd7};
    localparam logic [23:0] E_MWR     = {3'b000, 3'b000, 1'b0, 3'b000, 5'b00000, 5'b01000, 4'd8};
    localparam logic [23:0] E_WBALU   = {3'b000, 3'b000, 1'b0, 3'b000, 5'b00000, 5'b00100, 4'd9};
    localparam logic [23:0] E_WBMEM   = {3'b000, 3'b000, 1'b0, 3'b000, 5'b00000, 5'b00110, 4'd10};
    localparam logic [23:0] E_BR_T    = {3'b011, 3'b010, 1'b1, 3'b000, 5'b00000, 5'b00000, 4'd11};
    localparam logic [23:0] E_BR_N    = {3'b000, 3'b010, 1'b1, 3'b000, 5'b00000, 5'b00000, 4'd11};
    localparam logic [23:0] E_NPC     = {3'b010, 3'b001, 1'b0, 3'b001, 5'b00000, 5'b00000, 4'd12};
    localparam logic [23:0] E_TRAP    = {3'b000, 3'b000, 1'b0, 3'b000, 5'b00000, 5'b00001, 4'd15};

    typedef struct {
        logic [23:0] v;
        string       name;
        int          step;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   step = 0;
    event probe;

    task automatic push(input logic [23:0] v);
        exp_t e;
        e.v    = v;
        e.name = tname;
        e.step = step;
        q.push_back(e);
        step++;
    endtask

    // Monitor: one expected vector per sampled cycle, or per asynchronous probe
    always @(negedge clk or probe) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            compared++;
            if (obs[sel] !== e.v) begin
                mismatched++;
                $display("FAIL %s step %0d (W=%0d): got %h, want %h",
                         e.name, e.step, sel, obs[sel], e.v);
            end
        end
    end

    // Hold reset low, check the asynchronous RESET outputs, then release
    task automatic begin_test(input int s, input logic [31:0] i, input logic z, input string n);
        Reset = 1'b0;
        sel   = s;
        inst  = i;
        zero  = z;
        tname = n;
        step  = 0;
        #1;
        push(E_RESET);
        ->probe;
        @(posedge clk);
        #1;
        Reset = 1'b1;
        push(E_RESET);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s timeout: got %0d pending, want 0", tname, q.size());
            q.delete();
        end
    endtask

    initial begin
        #3;

        // sd on W=1, reset pulled in the first MEM_WR cycle
        begin_test(1, 32'h0020B023, 1'b0, "sd_abort");
        push(E_FETCH_W); push(E_FETCH_L); push(E_DECODE); push(E_ADDR); push(E_MWR);
        drain();
        Reset = 1'b0;
        tname = "rst_in_memwr";
        #1;
        push(E_RESET);
        ->probe;

        begin_test(1, 32'h002081B3, 1'b0, "add_w1");
        push(E_FETCH_W); push(E_FETCH_L); push(E_DECODE); push(E_EXR_ADD);
        push(E_WBALU); push(E_NPC); push(E_FETCH_W);
        drain();

        begin_test(1, 32'h402081B3, 1'b0, "sub_w1");
        push(E_FETCH_W); push(E_FETCH_L); push(E_DECODE); push(E_EXR_SUB);
        push(E_WBALU); push(E_NPC); push(E_FETCH_W);
        drain();

        begin_test(1, 32'h0020F1B3, 1'b0, "and_w1");
        push(E_FETCH_W); push(E_FETCH_L); push(E_DECODE); push(E_EXR_AND);
        push(E_WBALU); push(E_NPC); push(E_FETCH_W);
        drain();

        begin_test(2, 32'h0100B283, 1'b0, "ld_w2");
        push(E_FETCH_W); push(E_FETCH_W); push(E_FETCH_L); push(E_DECODE); push(E_ADDR);
        push(E_MRD_W); push(E_MRD_W); push(E_MRD_L); push(E_WBMEM); push(E_NPC);
        push(E_FETCH_W);
        drain();

        begin_test(1, 32'h0020B023, 1'b0, "sd_w1");
        push(E_FETCH_W); push(E_FETCH_L); push(E_DECODE); push(E_ADDR);
        push(E_MWR); push(E_MWR); push(E_NPC); push(E_FETCH_W);
        drain();

        begin_test(0, 32'h00208463, 1'b1, "beq_taken_w0");
        push(E_FETCH_L); push(E_DECODE); push(E_BR_T); push(E_FETCH_L);
        drain();

        begin_test(0, 32'h00208463, 1'b0, "beq_not_w0");
        push(E_FETCH_L); push(E_DECODE); push(E_BR_N); push(E_NPC); push(E_FETCH_L);
        drain();

        begin_test(0, 32'h00209463, 1'b0, "bne_taken_w0");
        push(E_FETCH_L); push(E_DECODE); push(E_BR_T); push(E_FETCH_L);
        drain();

        begin_test(0, 32'h00108093, 1'b0, "addi_w0");
        push(E_FETCH_L); push(E_DECODE); push(E_EXI); push(E_WBALU); push(E_NPC); push(E_FETCH_L);
        drain();

        begin_test(0, 32'h000010B7, 1'b0, "lui_w0");
        push(E_FETCH_L); push(E_DECODE); push(E_LUI); push(E_WBALU); push(E_NPC); push(E_FETCH_L);
        drain();

        begin_test(1, 32'h00000000, 1'b0, "trap_w1");
        push(E_FETCH_W); push(E_FETCH_L); push(E_DECODE);
        for (int k = 0; k < 22; k++) push(E_TRAP);
        drain();
        Reset = 1'b0;
        tname = "trap_reset";
        #1;
        push(E_RESET);
        ->probe;
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
